// File: rtl/mem_access_arbiter.sv
// Processor-wide width constants followed by the fetch / load-store arbiter
// that serialises both ports onto the single-port data memory.
package simple_processor_pkg;
  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned ADDR_WIDTH = 32;
endpackage

module mem_access_arbiter
  import simple_processor_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,

  input  logic                  if_req_i,
  input  logic [ADDR_WIDTH-1:0] if_addr_i,
  output logic                  if_gnt_o,
  output logic                  if_rvalid_o,
  output logic [DATA_WIDTH-1:0] if_rdata_o,
  output logic                  if_err_o,

  input  logic                  ls_req_i,
  input  logic                  ls_we_i,
  input  logic [ADDR_WIDTH-1:0] ls_addr_i,
  input  logic [DATA_WIDTH-1:0] ls_wdata_i,
  output logic                  ls_gnt_o,
  output logic                  ls_rvalid_o,
  output logic [DATA_WIDTH-1:0] ls_rdata_o,
  output logic                  ls_err_o,

  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  input  logic                  mem_ready_i
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RESP
  } state_t;

  state_t                state_q, state_d;
  logic                  owner_ls_q;
  logic                  last_ls_q;
  logic [ADDR_WIDTH-1:0] cmd_addr_q;
  logic                  cmd_we_q;
  logic [DATA_WIDTH-1:0] cmd_wdata_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] if_rdata_q;
  logic [DATA_WIDTH-1:0] ls_rdata_q;

  logic                  pick_ls;
  logic                  timeout;
  logic                  finish;
  logic [DATA_WIDTH-1:0] resp_data;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    if_gnt_o = 1'b0;
    ls_gnt_o = 1'b0;
    pick_ls  = 1'b0;
    timeout  = 1'b0;
    finish   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // Gated by reset so no grant is ever shown for a command that is dropped.
        if (!rst_i) begin
          if (if_req_i && ls_req_i) pick_ls = !last_ls_q;
          else                      pick_ls = ls_req_i;
          if_gnt_o = if_req_i && !pick_ls;
          ls_gnt_o = ls_req_i && pick_ls;
          if (if_req_i || ls_req_i) state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        timeout = !mem_ready_i && (cnt_q == CNT_LAST);
        finish  = mem_ready_i || timeout;
        if (finish) state_d = ST_RESP;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    resp_data = '0;
    if (mem_ready_i && !cmd_we_q) resp_data = mem_rdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      owner_ls_q  <= 1'b0;
      last_ls_q   <= 1'b1;
      cmd_addr_q  <= '0;
      cmd_we_q    <= 1'b0;
      cmd_wdata_q <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      if_rdata_q  <= '0;
      ls_rdata_q  <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (if_gnt_o || ls_gnt_o) begin
            owner_ls_q  <= ls_gnt_o;
            last_ls_q   <= ls_gnt_o;
            cmd_addr_q  <= ls_gnt_o ? ls_addr_i : if_addr_i;
            cmd_we_q    <= ls_gnt_o && ls_we_i;
            cmd_wdata_q <= ls_gnt_o ? ls_wdata_i : '0;
            cnt_q       <= '0;
          end
        end
        ST_ACCESS: begin
          if (finish) begin
            err_q <= timeout;
            if (owner_ls_q) ls_rdata_q <= resp_data;
            else            if_rdata_q <= resp_data;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_req_o   = (state_q == ST_ACCESS);
  assign mem_we_o    = mem_req_o && cmd_we_q;
  assign mem_addr_o  = cmd_addr_q;
  assign mem_wdata_o = cmd_wdata_q;

  assign if_rvalid_o = (state_q == ST_RESP) && !owner_ls_q;
  assign ls_rvalid_o = (state_q == ST_RESP) && owner_ls_q;
  assign if_err_o    = if_rvalid_o && err_q;
  assign ls_err_o    = ls_rvalid_o && err_q;
  assign if_rdata_o  = if_rdata_q;
  assign ls_rdata_o  = ls_rdata_q;

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Directed bench for mem_access_arbiter: expected responses are queued at grant
// time and a negedge monitor checks every rvalid pulse against the queue.
module tb_mem_access_arbiter;
  import simple_processor_pkg::*;

  localparam int unsigned TO = 16;

  logic                  clk = 1'b0;
  logic                  rst_i;
  logic                  if_req_i, ls_req_i, ls_we_i, mem_ready_i;
  logic [ADDR_WIDTH-1:0] if_addr_i, ls_addr_i;
  logic [DATA_WIDTH-1:0] ls_wdata_i, mem_rdata_i;
  logic                  if_gnt_o, if_rvalid_o, if_err_o;
  logic                  ls_gnt_o, ls_rvalid_o, ls_err_o;
  logic [DATA_WIDTH-1:0] if_rdata_o, ls_rdata_o, mem_wdata_o;
  logic                  mem_req_o, mem_we_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;

  always #5 clk = ~clk;

  mem_access_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o), .if_err_o(if_err_o),
    .ls_req_i(ls_req_i), .ls_we_i(ls_we_i), .ls_addr_i(ls_addr_i),
    .ls_wdata_i(ls_wdata_i), .ls_gnt_o(ls_gnt_o), .ls_rvalid_o(ls_rvalid_o),
    .ls_rdata_o(ls_rdata_o), .ls_err_o(ls_err_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ready_i(mem_ready_i)
  );

  typedef struct {
    bit                    ls;
    logic [DATA_WIDTH-1:0] data;
    bit                    err;
  } exp_t;

  exp_t                  sb[$];
  int                    n_cmp = 0;
  int                    n_bad = 0;
  logic [DATA_WIDTH-1:0] m_if_rdata = '0;
  logic [DATA_WIDTH-1:0] m_ls_rdata = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst_i && (if_rvalid_o || ls_rvalid_o)) begin
      chk("single_rvalid", {63'd0, if_rvalid_o && ls_rvalid_o}, 64'd0);
      if (sb.size() == 0) begin
        chk("unexpected_rvalid", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("resp_port", {63'd0, ls_rvalid_o}, {63'd0, e.ls});
        if (e.ls) begin
          chk("ls_rdata", ls_rdata_o, e.data);
          chk("ls_err", ls_err_o, e.err);
          chk("if_rdata_kept", if_rdata_o, m_if_rdata);
          m_ls_rdata = e.data;
        end else begin
          chk("if_rdata", if_rdata_o, e.data);
          chk("if_err", if_err_o, e.err);
          chk("ls_rdata_kept", ls_rdata_o, m_ls_rdata);
          m_if_rdata = e.data;
        end
      end
    end
  end

  task automatic push_exp(input bit ls, input logic [DATA_WIDTH-1:0] data, input bit err);
    exp_t e;
    e.ls = ls; e.data = data; e.err = err;
    sb.push_back(e);
  endtask

  // One complete access from IDLE: grant, ACCESS cycles, RESP; ends at the next IDLE.
  task automatic run_access(input bit ls, input bit we, input logic [ADDR_WIDTH-1:0] addr,
                            input logic [DATA_WIDTH-1:0] wdata, input logic [DATA_WIDTH-1:0] rd,
                            input int unsigned waits, input bit to);
    int unsigned n;
    n = to ? TO : waits + 1;
    if (ls) begin
      ls_req_i = 1'b1; ls_we_i = we; ls_addr_i = addr; ls_wdata_i = wdata;
    end else begin
      if_req_i = 1'b1; if_addr_i = addr;
    end
    @(negedge clk);
    chk("gnt", ls ? ls_gnt_o : if_gnt_o, 1);
    chk("other_gnt", ls ? if_gnt_o : ls_gnt_o, 0);
    chk("idle_mem_req", mem_req_o, 0);
    push_exp(ls, (to || we) ? '0 : rd, to);
    step();
    if_req_i = 1'b0; ls_req_i = 1'b0; ls_we_i = 1'b0;
    if_addr_i = 'hEEEE; ls_addr_i = 'hFFFF; ls_wdata_i = 'hFFFF;
    for (int unsigned i = 0; i < n; i++) begin
      mem_ready_i = !to && (i == waits);
      mem_rdata_i = mem_ready_i ? rd : (32'hBAD0_0000 + i);
      @(negedge clk);
      chk("acc_req", mem_req_o, 1);
      chk("acc_addr", mem_addr_o, addr);
      chk("acc_we", mem_we_o, we && ls);
      if (ls) chk("acc_wdata", mem_wdata_o, wdata);
      chk("acc_no_rvalid", if_rvalid_o || ls_rvalid_o, 0);
      step();
    end
    mem_ready_i = 1'b0; mem_rdata_i = 'hBAD1;
    @(negedge clk);
    chk("resp_mem_req", mem_req_o, 0);
    chk("resp_mem_we", mem_we_o, 0);
    chk("resp_rvalid", ls ? ls_rvalid_o : if_rvalid_o, 1);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [ADDR_WIDTH-1:0] ea;
    bit                    want_ls;
    rst_i = 1'b1; if_req_i = 0; ls_req_i = 0; ls_we_i = 0; mem_ready_i = 0;
    if_addr_i = '0; ls_addr_i = '0; ls_wdata_i = '0; mem_rdata_i = '0;
    step(); step();
    @(negedge clk);
    chk("rst_outputs", {mem_req_o, mem_we_o, if_rvalid_o, ls_rvalid_o, if_err_o, ls_err_o}, 0);
    chk("rst_rdata", {if_rdata_o, ls_rdata_o}, 0);
    chk("rst_mem_bus", {mem_addr_o, mem_wdata_o}, 0);
    step();
    rst_i = 1'b0;

    // Fetch read, ready on the first ACCESS cycle.
    run_access(0, 0, 'h10, '0, 32'hDEAD_BEEF, 0, 0);
    // Store with three wait states.
    run_access(1, 1, 'h20, 'h1234, 32'h5555_AAAA, 3, 0);

    // Contention: both ports keep requesting.
    if_req_i = 1'b1; ls_req_i = 1'b1; ls_we_i = 1'b0;
    if_addr_i = 'h100; ls_addr_i = 'h200;
    for (int k = 0; k < 4; k++) begin
      want_ls = k[0];
      ea = (want_ls ? 'h200 : 'h100) + 4 * (k / 2);
      @(negedge clk);
      chk("cont_if_gnt", if_gnt_o, !want_ls);
      chk("cont_ls_gnt", ls_gnt_o, want_ls);
      push_exp(want_ls, 32'hA000_0000 + k, 0);
      step();
      if (want_ls) ls_addr_i = ls_addr_i + 4;
      else         if_addr_i = if_addr_i + 4;
      mem_ready_i = 1'b1; mem_rdata_i = 32'hA000_0000 + k;
      @(negedge clk);
      chk("cont_addr", mem_addr_o, ea);
      chk("cont_busy_gnt", {if_gnt_o, ls_gnt_o}, 0);
      step();
      mem_ready_i = 1'b0;
      @(negedge clk);
      chk("cont_resp_gnt", {if_gnt_o, ls_gnt_o}, 0);
      step();
    end
    if_req_i = 1'b0; ls_req_i = 1'b0;

    // Load that never sees ready, then ready exactly on the last allowed cycle.
    run_access(1, 0, 'h30, '0, 32'h1111_2222, 0, 1);
    run_access(1, 0, 'h50, '0, 32'h600D_F00D, TO - 1, 0);

    // Ready outside ACCESS must do nothing.
    mem_ready_i = 1'b1; mem_rdata_i = 'h9999;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("idle_ready_ignored", mem_req_o, 0);
      step();
    end
    mem_ready_i = 1'b0;

    // Late LS request during a fetch ACCESS.
    if_req_i = 1'b1; if_addr_i = 'h60;
    @(negedge clk);
    chk("late_if_gnt", if_gnt_o, 1);
    push_exp(0, 32'h7777_0000, 0);
    step();
    if_req_i = 1'b0; ls_req_i = 1'b1; ls_we_i = 1'b0; ls_addr_i = 'h70;
    @(negedge clk);
    chk("late_no_gnt_acc1", ls_gnt_o, 0);
    step();
    mem_ready_i = 1'b1; mem_rdata_i = 32'h7777_0000;
    @(negedge clk);
    chk("late_no_gnt_acc2", ls_gnt_o, 0);
    step();
    mem_rdata_i = 'hBAD2;
    @(negedge clk);
    chk("late_no_gnt_resp", ls_gnt_o, 0);
    chk("late_if_rvalid", if_rvalid_o, 1);
    step();
    mem_ready_i = 1'b0;
    @(negedge clk);
    chk("late_ls_gnt", ls_gnt_o, 1);
    push_exp(1, 32'h8888_0001, 0);
    step();
    ls_req_i = 1'b0; mem_ready_i = 1'b1; mem_rdata_i = 32'h8888_0001;
    @(negedge clk);
    chk("late_ls_addr", mem_addr_o, 'h70);
    step();
    mem_ready_i = 1'b0;
    @(negedge clk);
    chk("late_ls_rvalid", ls_rvalid_o, 1);
    step();

    // Reset pulsed during the second ACCESS cycle of a fetch.
    if_req_i = 1'b1; if_addr_i = 'h80;
    @(negedge clk);
    chk("rstmid_if_gnt", if_gnt_o, 1);
    step();
    if_req_i = 1'b0;
    @(negedge clk);
    chk("rstmid_acc1", mem_req_o, 1);
    step();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    m_if_rdata = '0; m_ls_rdata = '0;
    @(negedge clk);
    chk("rstmid_ctrl", {mem_req_o, mem_we_o, if_rvalid_o, ls_rvalid_o, if_err_o, ls_err_o}, 0);
    chk("rstmid_rdata", {if_rdata_o, ls_rdata_o}, 0);
    chk("rstmid_bus", {mem_addr_o, mem_wdata_o}, 0);
    step();
    if_req_i = 1'b1; ls_req_i = 1'b1; if_addr_i = 'h90; ls_addr_i = 'hA0;
    @(negedge clk);
    chk("rstmid_tie_if", if_gnt_o, 1);
    chk("rstmid_tie_ls", ls_gnt_o, 0);
    push_exp(0, 32'hC0DE, 0);
    step();
    if_req_i = 1'b0; ls_req_i = 1'b0; mem_ready_i = 1'b1; mem_rdata_i = 32'hC0DE;
    step();
    mem_ready_i = 1'b0;
    step(); step(); step();
    chk("scoreboard_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
